// File: rtl/inst_encoder_pkg.sv
// ============================================================================
// Module   : inst_encoder_pkg
// Purpose  : RV32IM ISA constants (opcodes, funct3, funct7) and micro-arch
//            types (rv_uop, buffer entry) shared by the encoder.
//            Macro INST_ENCODER_RVM_EN adds the M-extension constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

   // ---------------------------------------------------------------- ISA
   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;

   localparam logic [2:0] c_f3_add_sub = 3'b000;
   localparam logic [2:0] c_f3_sll     = 3'b001;
   localparam logic [2:0] c_f3_slt     = 3'b010;
   localparam logic [2:0] c_f3_sltu    = 3'b011;
   localparam logic [2:0] c_f3_xor     = 3'b100;
   localparam logic [2:0] c_f3_srl_sra = 3'b101;
   localparam logic [2:0] c_f3_or      = 3'b110;
   localparam logic [2:0] c_f3_and     = 3'b111;

   localparam logic [2:0] c_f3_lb      = 3'b000;
   localparam logic [2:0] c_f3_lh      = 3'b001;
   localparam logic [2:0] c_f3_lw      = 3'b010;
   localparam logic [2:0] c_f3_lbu     = 3'b100;
   localparam logic [2:0] c_f3_lhu     = 3'b101;

   localparam logic [2:0] c_f3_sb      = 3'b000;
   localparam logic [2:0] c_f3_sh      = 3'b001;
   localparam logic [2:0] c_f3_sw      = 3'b010;

   localparam logic [2:0] c_f3_beq     = 3'b000;
   localparam logic [2:0] c_f3_bne     = 3'b001;
   localparam logic [2:0] c_f3_blt     = 3'b100;
   localparam logic [2:0] c_f3_bge     = 3'b101;
   localparam logic [2:0] c_f3_bltu    = 3'b110;
   localparam logic [2:0] c_f3_bgeu    = 3'b111;

   localparam logic [2:0] c_f3_jalr    = 3'b000;

   localparam logic [6:0] c_f7_base    = 7'b0000000;
   localparam logic [6:0] c_f7_alt     = 7'b0100000;

`ifdef INST_ENCODER_RVM_EN
   localparam logic [6:0] c_f7_muldiv  = 7'b0000001;
   localparam logic [2:0] c_f3_mul     = 3'b000;
   localparam logic [2:0] c_f3_mulh    = 3'b001;
   localparam logic [2:0] c_f3_mulhsu  = 3'b010;
   localparam logic [2:0] c_f3_mulhu   = 3'b011;
   localparam logic [2:0] c_f3_div     = 3'b100;
   localparam logic [2:0] c_f3_divu    = 3'b101;
   localparam logic [2:0] c_f3_rem     = 3'b110;
   localparam logic [2:0] c_f3_remu    = 3'b111;
`endif

   localparam logic [31:0] c_nop = 32'h0000_0013;

   // ---------------------------------------------------------------- UArch
   typedef enum logic [5:0] {
      UOP_ADD = 6'd0, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR,
      UOP_SRL, UOP_SRA, UOP_OR, UOP_AND,
      UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU,
      UOP_SB, UOP_SH, UOP_SW,
      UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU,
      UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
      UOP_MUL, UOP_MULH, UOP_MULHSU, UOP_MULHU,
      UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU
   } rv_uop;

   typedef enum logic [3:0] {
      K_BAD, K_REG, K_IMM, K_SHIFT, K_LOAD, K_STORE,
      K_BRANCH, K_LUI, K_AUIPC, K_JAL, K_JALR
   } enc_kind_t;

   typedef struct packed {
      logic [31:0] inst;
      logic        illegal;
   } enc_entry_t;

   // True when v is representable as a two's-complement value of 'bits' bits.
   function automatic logic fits_simm(input logic [31:0] v, input int unsigned bits);
      logic [31:0] upper;
      upper = $signed(v) >>> (bits - 1);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encode_fields.sv
// ============================================================================
// Module   : inst_encode_fields
// Purpose  : Combinational map of one request to {inst, illegal}.
//            Macro INST_ENCODER_RVM_EN enables the M-extension uops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encode_fields
   import inst_encoder_pkg::*;
(
   input  rv_uop       uop,
   input  logic        op2_imm,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        illegal
);

   enc_kind_t   w_kind;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_raw;
   logic        w_bad;

   // Classify the uop into an encoding format plus its funct fields.
   always_comb begin
      w_kind = K_BAD;
      w_f3   = 3'b000;
      w_f7   = c_f7_base;
      case (uop)
         UOP_ADD:   begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_add_sub; end
         UOP_SUB:   begin w_kind = op2_imm ? K_BAD : K_REG;   w_f3 = c_f3_add_sub; w_f7 = c_f7_alt; end
         UOP_SLL:   begin w_kind = op2_imm ? K_SHIFT : K_REG; w_f3 = c_f3_sll; end
         UOP_SLT:   begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_slt; end
         UOP_SLTU:  begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_sltu; end
         UOP_XOR:   begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_xor; end
         UOP_SRL:   begin w_kind = op2_imm ? K_SHIFT : K_REG; w_f3 = c_f3_srl_sra; end
         UOP_SRA:   begin w_kind = op2_imm ? K_SHIFT : K_REG; w_f3 = c_f3_srl_sra; w_f7 = c_f7_alt; end
         UOP_OR:    begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_or; end
         UOP_AND:   begin w_kind = op2_imm ? K_IMM : K_REG;   w_f3 = c_f3_and; end
         UOP_LB:    begin w_kind = K_LOAD;   w_f3 = c_f3_lb; end
         UOP_LH:    begin w_kind = K_LOAD;   w_f3 = c_f3_lh; end
         UOP_LW:    begin w_kind = K_LOAD;   w_f3 = c_f3_lw; end
         UOP_LBU:   begin w_kind = K_LOAD;   w_f3 = c_f3_lbu; end
         UOP_LHU:   begin w_kind = K_LOAD;   w_f3 = c_f3_lhu; end
         UOP_SB:    begin w_kind = K_STORE;  w_f3 = c_f3_sb; end
         UOP_SH:    begin w_kind = K_STORE;  w_f3 = c_f3_sh; end
         UOP_SW:    begin w_kind = K_STORE;  w_f3 = c_f3_sw; end
         UOP_BEQ:   begin w_kind = K_BRANCH; w_f3 = c_f3_beq; end
         UOP_BNE:   begin w_kind = K_BRANCH; w_f3 = c_f3_bne; end
         UOP_BLT:   begin w_kind = K_BRANCH; w_f3 = c_f3_blt; end
         UOP_BGE:   begin w_kind = K_BRANCH; w_f3 = c_f3_bge; end
         UOP_BLTU:  begin w_kind = K_BRANCH; w_f3 = c_f3_bltu; end
         UOP_BGEU:  begin w_kind = K_BRANCH; w_f3 = c_f3_bgeu; end
         UOP_LUI:   w_kind = K_LUI;
         UOP_AUIPC: w_kind = K_AUIPC;
         UOP_JAL:   w_kind = K_JAL;
         UOP_JALR:  begin w_kind = K_JALR;   w_f3 = c_f3_jalr; end
`ifdef INST_ENCODER_RVM_EN
         UOP_MUL:    begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_mul;    w_f7 = c_f7_muldiv; end
         UOP_MULH:   begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_mulh;   w_f7 = c_f7_muldiv; end
         UOP_MULHSU: begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_mulhsu; w_f7 = c_f7_muldiv; end
         UOP_MULHU:  begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_mulhu;  w_f7 = c_f7_muldiv; end
         UOP_DIV:    begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_div;    w_f7 = c_f7_muldiv; end
         UOP_DIVU:   begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_divu;   w_f7 = c_f7_muldiv; end
         UOP_REM:    begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_rem;    w_f7 = c_f7_muldiv; end
         UOP_REMU:   begin w_kind = op2_imm ? K_BAD : K_REG; w_f3 = c_f3_remu;   w_f7 = c_f7_muldiv; end
`endif
         default:   w_kind = K_BAD;
      endcase
   end

   // Assemble the instruction word and check that the immediate fits its field.
   always_comb begin
      w_raw = c_nop;
      w_bad = 1'b0;
      case (w_kind)
         K_REG:    w_raw = {w_f7, rs2, rs1, w_f3, rd, c_opc_op};
         K_IMM:    begin
                      w_raw = {imm[11:0], rs1, w_f3, rd, c_opc_op_imm};
                      w_bad = !fits_simm(imm, 12);
                   end
         K_SHIFT:  begin
                      w_raw = {w_f7, imm[4:0], rs1, w_f3, rd, c_opc_op_imm};
                      w_bad = |imm[31:5];
                   end
         K_LOAD:   begin
                      w_raw = {imm[11:0], rs1, w_f3, rd, c_opc_load};
                      w_bad = !fits_simm(imm, 12);
                   end
         K_JALR:   begin
                      w_raw = {imm[11:0], rs1, w_f3, rd, c_opc_jalr};
                      w_bad = !fits_simm(imm, 12);
                   end
         K_STORE:  begin
                      w_raw = {imm[11:5], rs2, rs1, w_f3, imm[4:0], c_opc_store};
                      w_bad = !fits_simm(imm, 12);
                   end
         K_BRANCH: begin
                      w_raw = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], c_opc_branch};
                      w_bad = !fits_simm(imm, 13) || imm[0];
                   end
         K_LUI:    begin
                      w_raw = {imm[31:12], rd, c_opc_lui};
                      w_bad = |imm[11:0];
                   end
         K_AUIPC:  begin
                      w_raw = {imm[31:12], rd, c_opc_auipc};
                      w_bad = |imm[11:0];
                   end
         K_JAL:    begin
                      w_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c_opc_jal};
                      w_bad = !fits_simm(imm, 21) || imm[0];
                   end
         default:  w_bad = 1'b1;
      endcase
   end

   assign inst    = w_bad ? c_nop : w_raw;
   assign illegal = w_bad;

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// Module   : inst_encoder
// Purpose  : RV32IM instruction encoder with an in-order p_depth output FIFO
//            and a completed-response counter. Macro: INST_ENCODER_RVM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int unsigned p_depth = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_val,
   output logic        req_rdy,
   input  rv_uop       req_uop,
   input  logic        req_op2_imm,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [4:0]  req_rd,
   input  logic [31:0] req_imm,
   input  logic        flush,
   output logic        resp_val,
   input  logic        resp_rdy,
   output logic [31:0] resp_inst,
   output logic        resp_illegal,
   output logic [15:0] num_encoded
);

   localparam int unsigned c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int unsigned c_cnt_w = $clog2(p_depth + 1);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(p_depth);
   localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(p_depth - 1);

   logic [31:0]        w_inst;
   logic               w_illegal;
   logic               w_enq;
   logic               w_deq;
   enc_entry_t         r_mem [p_depth];
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_cnt_w-1:0] r_count;
   logic [15:0]        r_num;

   inst_encode_fields u_fields (
      .uop     (req_uop),
      .op2_imm (req_op2_imm),
      .rs1     (req_rs1),
      .rs2     (req_rs2),
      .rd      (req_rd),
      .imm     (req_imm),
      .inst    (w_inst),
      .illegal (w_illegal)
   );

   // No full-bypass: a full buffer refuses input even while draining.
   assign req_rdy  = rst_n && (r_count < c_depth) && !flush;
   assign resp_val = (r_count != '0);
   assign w_enq    = req_val && req_rdy;
   assign w_deq    = resp_val && resp_rdy && !flush;

   assign resp_inst    = r_mem[r_head].inst;
   assign resp_illegal = r_mem[r_head].illegal;
   assign num_encoded  = r_num;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_num   <= '0;
      end else if (flush) begin
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_enq) begin
            r_tail <= (r_tail == c_last) ? '0 : r_tail + 1'b1;
         end
         if (w_deq) begin
            r_head <= (r_head == c_last) ? '0 : r_head + 1'b1;
            r_num  <= r_num + 16'd1;
         end
      end
   end

   // Payload storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_tail] <= '{inst: w_inst, illegal: w_illegal};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module   : tb_inst_encoder
// Purpose  : Self-checking bench for inst_encoder: directed cases, random
//            traffic against a queue model, and a counter-wrap stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;
   import inst_encoder_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        req_val;
   logic        req_rdy;
   rv_uop       req_uop;
   logic        req_op2_imm;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [4:0]  req_rd;
   logic [31:0] req_imm;
   logic        flush;
   logic        resp_val;
   logic        resp_rdy;
   logic [31:0] resp_inst;
   logic        resp_illegal;
   logic [15:0] num_encoded;

   int n_checks = 0;
   int n_errors = 0;

   inst_encoder #(.p_depth(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_val      (req_val),
      .req_rdy      (req_rdy),
      .req_uop      (req_uop),
      .req_op2_imm  (req_op2_imm),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_rd       (req_rd),
      .req_imm      (req_imm),
      .flush        (flush),
      .resp_val     (resp_val),
      .resp_rdy     (resp_rdy),
      .resp_inst    (resp_inst),
      .resp_illegal (resp_illegal),
      .num_encoded  (num_encoded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        ill;
   } exp_t;

   exp_t        m_q [$];
   logic [15:0] m_num;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoder: field positions computed by shifts and masks on the
   // immediate, legality by plain integer range checks.
   function automatic exp_t model_encode(input rv_uop u, input logic oi,
                                         input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] d, input logic [31:0] im);
      exp_t        r;
      int          s;
      int          f3;
      int          f7;
      string       fmt;
      logic        ok;
      logic [31:0] w;
      s = int'(im);
      f3 = 0; f7 = 0; ok = 1'b1; fmt = "BAD";
      case (u)
         UOP_ADD:  begin fmt = oi ? "I" : "R"; f3 = 0; end
         UOP_SUB:  begin fmt = oi ? "BAD" : "R"; f3 = 0; f7 = 32; end
         UOP_SLL:  begin fmt = oi ? "SH" : "R"; f3 = 1; end
         UOP_SLT:  begin fmt = oi ? "I" : "R"; f3 = 2; end
         UOP_SLTU: begin fmt = oi ? "I" : "R"; f3 = 3; end
         UOP_XOR:  begin fmt = oi ? "I" : "R"; f3 = 4; end
         UOP_SRL:  begin fmt = oi ? "SH" : "R"; f3 = 5; end
         UOP_SRA:  begin fmt = oi ? "SH" : "R"; f3 = 5; f7 = 32; end
         UOP_OR:   begin fmt = oi ? "I" : "R"; f3 = 6; end
         UOP_AND:  begin fmt = oi ? "I" : "R"; f3 = 7; end
         UOP_LB:   begin fmt = "L"; f3 = 0; end
         UOP_LH:   begin fmt = "L"; f3 = 1; end
         UOP_LW:   begin fmt = "L"; f3 = 2; end
         UOP_LBU:  begin fmt = "L"; f3 = 4; end
         UOP_LHU:  begin fmt = "L"; f3 = 5; end
         UOP_SB:   begin fmt = "S"; f3 = 0; end
         UOP_SH:   begin fmt = "S"; f3 = 1; end
         UOP_SW:   begin fmt = "S"; f3 = 2; end
         UOP_BEQ:  begin fmt = "B"; f3 = 0; end
         UOP_BNE:  begin fmt = "B"; f3 = 1; end
         UOP_BLT:  begin fmt = "B"; f3 = 4; end
         UOP_BGE:  begin fmt = "B"; f3 = 5; end
         UOP_BLTU: begin fmt = "B"; f3 = 6; end
         UOP_BGEU: begin fmt = "B"; f3 = 7; end
         UOP_LUI:  fmt = "LUI";
         UOP_AUIPC: fmt = "AUIPC";
         UOP_JAL:  fmt = "J";
         UOP_JALR: fmt = "JR";
`ifdef INST_ENCODER_RVM_EN
         UOP_MUL, UOP_MULH, UOP_MULHSU, UOP_MULHU,
         UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU: begin
            fmt = oi ? "BAD" : "R";
            f3 = int'(u) - int'(UOP_MUL);
            f7 = 1;
         end
`endif
         default:  fmt = "BAD";
      endcase
      w = 32'h0;
      if (fmt == "R") begin
         w = (32'(f7) << 25) | (32'(b) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'd51;
      end else if (fmt == "I" || fmt == "L" || fmt == "JR") begin
         ok = (s >= -2048) && (s <= 2047);
         w = ((im & 32'hFFF) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7)
           | ((fmt == "I") ? 32'd19 : (fmt == "L") ? 32'd3 : 32'd103);
      end else if (fmt == "SH") begin
         ok = (im <= 32'd31);
         w = (32'(f7) << 25) | ((im & 32'h1F) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'd19;
      end else if (fmt == "S") begin
         ok = (s >= -2048) && (s <= 2047);
         w = (((im >> 5) & 32'h7F) << 25) | (32'(b) << 20) | (32'(a) << 15) | (32'(f3) << 12)
           | ((im & 32'h1F) << 7) | 32'd35;
      end else if (fmt == "B") begin
         ok = (s >= -4096) && (s <= 4095) && (im % 2 == 0);
         w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(b) << 20) | (32'(a) << 15)
           | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'd99;
      end else if (fmt == "LUI" || fmt == "AUIPC") begin
         ok = (im % 4096 == 0);
         w = im | (32'(d) << 7) | ((fmt == "LUI") ? 32'd55 : 32'd23);
      end else if (fmt == "J") begin
         ok = (s >= -1048576) && (s <= 1048575) && (im % 2 == 0);
         w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
           | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'd111;
      end else begin
         ok = 1'b0;
      end
      r.ill  = !ok;
      r.inst = ok ? w : 32'h0000_0013;
      return r;
   endfunction

   // Model state: updated on the same edge as the DUT, from the same inputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_num <= 16'd0;
      end else if (flush) begin
         m_q.delete();
      end else if (m_q.size() != 0 && resp_rdy) begin
         if (req_val && m_q.size() < DEPTH)
            m_q.push_back(model_encode(req_uop, req_op2_imm, req_rs1, req_rs2, req_rd, req_imm));
         void'(m_q.pop_front());
         m_num <= m_num + 16'd1;
      end else if (req_val && m_q.size() < DEPTH) begin
         m_q.push_back(model_encode(req_uop, req_op2_imm, req_rs1, req_rs2, req_rd, req_imm));
      end
   end

   always @(negedge clk) begin
      logic exp_rdy;
      exp_rdy = rst_n && (m_q.size() < DEPTH) && !flush;
      chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("resp_val", 32'(resp_val), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("resp_inst", resp_inst, m_q[0].inst);
         chk("resp_illegal", 32'(resp_illegal), 32'(m_q[0].ill));
      end
      chk("num_encoded", 32'(num_encoded), 32'(m_num));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input rv_uop u, input logic oi, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d, input logic [31:0] im);
      req_val = 1'b1; req_uop = u; req_op2_imm = oi;
      req_rs1 = a; req_rs2 = b; req_rd = d; req_imm = im;
   endtask

   function automatic logic [31:0] pick_imm();
      case ($urandom_range(0, 7))
         0: return 32'($urandom_range(0, 64)) - 32'd32;
         1: case ($urandom_range(0, 7))
               0: return 32'd2047;  1: return 32'd2048;
               2: return -32'd2048; 3: return -32'd2049;
               4: return 32'd31;    5: return 32'd32;
               6: return 32'd4094;  default: return -32'd4096;
            endcase
         2: return $urandom;
         3: return $urandom & 32'hFFFF_F000;
         4: return 32'($urandom_range(0, 40));
         5: return (32'($urandom_range(0, 8400)) - 32'd4200) & ~32'd1;
         6: case ($urandom_range(0, 4))
               0: return 32'h000F_FFFE; 1: return 32'h0010_0000;
               2: return 32'hFFF0_0000; 3: return 32'hFFEF_FFFE;
               default: return 32'd4096;
            endcase
         default: return 32'd4095;
      endcase
   endfunction

   initial begin
      exp_t pin;
      rst_n = 1'b0; req_val = 1'b0; req_uop = UOP_ADD; req_op2_imm = 1'b0;
      req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_imm = '0;
      flush = 1'b0; resp_rdy = 1'b0;

      // Pin the reference model on hand-encoded words.
      pin = model_encode(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      chk("model_add", pin.inst, 32'h0020_81B3);
      pin = model_encode(UOP_SRA, 1'b1, 5'd6, 5'd0, 5'd5, 32'd3);
      chk("model_srai", pin.inst, 32'h4033_5293);
      pin = model_encode(UOP_JAL, 1'b0, 5'd0, 5'd0, 5'd1, 32'd8);
      chk("model_jal", pin.inst, 32'h0080_00EF);
      pin = model_encode(UOP_SW, 1'b0, 5'd2, 5'd5, 5'd0, 32'd8);
      chk("model_sw", pin.inst, 32'h0051_2423);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_resp_val", 32'(resp_val), 32'd0);
      chk("rst_num", 32'(num_encoded), 32'd0);
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 32'(req_rdy), 32'd1);

      // ADD, one cycle latency.
      tick(); resp_rdy = 1'b1; set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      tick(); req_val = 1'b0;
      @(negedge clk);
      chk("add_val", 32'(resp_val), 32'd1);
      chk("add_inst", resp_inst, 32'h0020_81B3);
      chk("add_ill", 32'(resp_illegal), 32'd0);

      // SRAI then ADDI back to back.
      tick(); set_req(UOP_SRA, 1'b1, 5'd6, 5'd0, 5'd5, 32'd3);
      tick(); set_req(UOP_ADD, 1'b1, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      chk("srai_inst", resp_inst, 32'h4033_5293);
      tick(); req_val = 1'b0;
      @(negedge clk);
      chk("addi_inst", resp_inst, 32'h0050_0093);
      chk("num_2", 32'(num_encoded), 32'd2);

      // BEQ with odd immediate is illegal but still counted.
      tick(); set_req(UOP_BEQ, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3);
      tick(); req_val = 1'b0;
      @(negedge clk);
      chk("beq_ill", 32'(resp_illegal), 32'd1);
      chk("beq_nop", resp_inst, 32'h0000_0013);
      chk("num_3", 32'(num_encoded), 32'd3);
      tick();
      @(negedge clk);
      chk("num_4", 32'(num_encoded), 32'd4);

      // Back-pressure: third request refused, then in-order drain.
      tick(); resp_rdy = 1'b0; set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      tick(); set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd4, 32'd0);
      tick(); set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd5, 32'd0);
      @(negedge clk);
      chk("full_rdy", 32'(req_rdy), 32'd0);
      tick(); req_val = 1'b0; resp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_head0", resp_inst, 32'h0020_81B3);
      tick();
      @(negedge clk);
      chk("bp_head1", resp_inst, 32'h0020_8233);
      tick();
      @(negedge clk);
      chk("bp_empty", 32'(resp_val), 32'd0);
      chk("num_6", 32'(num_encoded), 32'd6);

      // Flush with two entries buffered.
      tick(); resp_rdy = 1'b0; set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      tick(); set_req(UOP_ADD, 1'b0, 5'd1, 5'd2, 5'd4, 32'd0);
      tick(); flush = 1'b1; resp_rdy = 1'b1;
      @(negedge clk);
      chk("flush_rdy", 32'(req_rdy), 32'd0);
      tick(); flush = 1'b0; req_val = 1'b0; resp_rdy = 1'b0;
      @(negedge clk);
      chk("flush_val", 32'(resp_val), 32'd0);
      chk("flush_rdy_after", 32'(req_rdy), 32'd1);
      chk("flush_num", 32'(num_encoded), 32'd6);

      // MUL: legal only with the M extension.
      tick(); resp_rdy = 1'b1; set_req(UOP_MUL, 1'b0, 5'd2, 5'd3, 5'd1, 32'd0);
      tick(); req_val = 1'b0;
      @(negedge clk);
`ifdef INST_ENCODER_RVM_EN
      chk("mul_inst", resp_inst, 32'h0231_00B3);
      chk("mul_ill", 32'(resp_illegal), 32'd0);
`else
      chk("mul_inst", resp_inst, 32'h0000_0013);
      chk("mul_ill", 32'(resp_illegal), 32'd1);
`endif

      // Random traffic with occasional flush and mid-run reset.
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst_n       = ($urandom_range(0, 499) != 0);
         req_val     = ($urandom_range(0, 3) != 0);
         req_uop     = rv_uop'(6'($urandom_range(0, 39)));
         req_op2_imm = 1'($urandom_range(0, 1));
         req_rs1     = 5'($urandom);
         req_rs2     = 5'($urandom);
         req_rd      = 5'($urandom);
         req_imm     = pick_imm();
         resp_rdy    = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 31) == 0);
      end

      // Continuous stream long enough to wrap num_encoded.
      tick();
      rst_n = 1'b1; flush = 1'b0; resp_rdy = 1'b1;
      set_req(UOP_XOR, 1'b1, 5'd7, 5'd0, 5'd9, 32'hFFFF_FFFF);
      repeat (66000) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter p_depth, default 2, the number of output buffer entries (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_val, input, 1 bit: request valid.
REQ-005 SHALL have port req_rdy, output, 1 bit: request ready.
REQ-006 SHALL have port req_uop, input, rv_uop: the operation to encode.
REQ-007 SHALL have port req_op2_imm, input, 1 bit: 1 selects the immediate form (ADDI vs ADD, etc.).
REQ-008 SHALL have ports req_rs1, req_rs2 and req_rd, each input, 5 bits: register specifiers.
REQ-009 SHALL have port req_imm, input, 32 bits: sign-extended immediate value.
REQ-010 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-011 SHALL have port resp_val, output, 1 bit: response valid.
REQ-012 SHALL have port resp_rdy, input, 1 bit: response ready.
REQ-013 SHALL have port resp_inst, output, 32 bits: the encoded RV32IM instruction.
REQ-014 SHALL have port resp_illegal, output, 1 bit: the request was not encodable.
REQ-015 SHALL have port num_encoded, output, 16 bits: count of completed responses.

Function
REQ-016 SHALL accept a request when req_val && req_rdy && !flush at a rising edge.
REQ-017 SHALL present the encoded result of an accepted request no earlier than the next cycle, with a minimum latency of 1 cycle.
REQ-018 SHALL buffer results in an in-order FIFO of p_depth entries, with a registered occupancy count.
REQ-019 SHALL drive req_rdy = (count < p_depth) && !flush, with no full-bypass: a full buffer with a simultaneous dequeue still deasserts req_rdy.
REQ-020 SHALL drive resp_val = (count != 0); resp_inst and resp_illegal SHALL be the head entry, held stable while resp_val && !resp_rdy.
REQ-021 SHALL, on simultaneous enqueue and dequeue, leave count unchanged.
REQ-022 SHALL use a wrapping head pointer and a wrapping tail pointer, each modulo p_depth.
REQ-023 SHALL, when flush is asserted, set count to 0 at the next edge; no enqueue or dequeue SHALL occur that cycle, and num_encoded SHALL NOT increment.
REQ-024 SHALL encode formats as follows:
  - R-type: uop, rs1, rs2, rd, op2_imm=0.
  - I-type: op2_imm=1 ALU ops, loads, JALR; imm[11:0].
  - Shifts with immediate: shamt = imm[4:0]; SRA funct7 = 0100000.
  - S-type: stores.
  - B-type: branches, imm[12:1].
  - U-type: LUI/AUIPC, imm[31:12].
  - J-type: JAL, imm[20:1].
REQ-025 SHALL flag illegal on any of the following:
  - I/S immediate outside [-2048, 2047].
  - Shift immediate outside 0..31.
  - B immediate outside 13-bit signed range, or imm[0]=1.
  - J immediate outside 21-bit signed range, or imm[0]=1.
  - U immediate with imm[11:0] != 0.
  - An unsupported uop.
  - op2_imm=1 on SUB or on R-only ops.
REQ-026 SHALL, for an illegal request, set resp_illegal=1 and resp_inst=32'h00000013 (NOP).
REQ-027 SHALL increment num_encoded on each resp_val && resp_rdy, including illegal responses, wrapping from 16'hFFFF to 0.

Reset
REQ-028 SHALL, while rst_n=0, clear count, head, tail and num_encoded asynchronously.
REQ-029 SHALL hold resp_val=0 and req_rdy=0 while rst_n=0, and SHALL reach req_rdy=1 in the first cycle after deassertion.
REQ-030 SHALL lose all in-flight entries when reset is asserted mid-operation; buffer data contents SHALL need no reset.

Configuration
REQ-031 SHALL use macro INST_ENCODER_RVM_EN to control M-extension support.
REQ-032 SHALL, when INST_ENCODER_RVM_EN is defined, encode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU (funct7 0000001).
REQ-033 SHALL, when INST_ENCODER_RVM_EN is undefined, treat those uops as illegal (REQ-026).

Structure
REQ-034 SHALL place opcode, funct3 and funct7 constants in the shared ISA package, and rv_uop in UArch.
REQ-035 SHALL contain one combinational sub-module, inst_encode_fields, mapping a request to {inst, illegal}; the FIFO and counter SHALL live in inst_encoder.

Verification
REQ-036 SHALL cover: ADD, op2_imm=0, rs1=1, rs2=2, rd=3 -> resp_inst 32'h002081B3, illegal=0, one cycle later.
REQ-037 SHALL cover: SRA, op2_imm=1, rs1=6, rd=5, imm=3 -> 32'h40335293; ADD with op2_imm=1, rs1=0, rd=1, imm=5 -> 32'h00500093.
REQ-038 SHALL cover: BEQ with imm=3 -> resp_illegal=1, resp_inst 32'h00000013, num_encoded incremented on handshake.
REQ-039 SHALL cover: resp_rdy=0 with three back-to-back requests -> two accepted, req_rdy=0 on the third; on release, in-order delivery.
REQ-040 SHALL cover: two entries buffered, then flush -> resp_val=0 next cycle, num_encoded unchanged, req_rdy=1.
REQ-041 SHALL cover: MUL, rs1=2, rs2=3, rd=1 -> 32'h023100B3 with INST_ENCODER_RVM_EN defined, illegal NOP without it.
